tlul_reg_responder: RTL
=======================

Name: tlul_reg_responder

Overview:
- TL-UL device-side responder: accepts host A-channel requests (Get, PutFullData, PutPartialData) and returns D-channel responses from a small bank of 32-bit registers.
- Sits at the device end of a TL-UL link, e.g. behind `tlul_cmd_intg_gen`-driven host sequences.
- Serves as a configurable-latency target for bus-level tests and as a scratch register block in SoC integration.
- Single outstanding transaction; response integrity is generated internally.

Parameters:
NumRegs, 8, number of 32-bit registers; word index = a_address[31:2]; must be 1..256
RspLatency, 0, extra wait cycles between request acceptance and d_valid assertion; 0..7

Ports:
clk_i  input  1  clock
rst_ni  input  1  asynchronous active-low reset
tl_i  input  tlul_pkg::tl_h2d_t  host request (A channel, d_ready)
tl_o  output  tlul_pkg::tl_d2h_t  device response (D channel, a_ready); d_user driven by an internal tlul_rsp_intg_gen
reg_o  output  NumRegs*32  flattened register contents; reg i at bits [32*i+31:32*i]

Behaviour:
- Clocking/reset: one clock `clk_i`; reset is asynchronous and active-low on `rst_ni`.
- Reset values: state IDLE; all registers 0; a_ready=1; d_valid=0; d_opcode=AccessAck; d_data=0; d_error=0; d_source=0; d_size=0; d_param=0; d_sink=0.
- FSM states: IDLE, WAIT, RESP.
  - IDLE: a_ready=1. On a_valid&&a_ready the request is accepted:
    - capture a_source, a_size, opcode;
    - evaluate error;
    - commit a write or sample read data at that edge;
    - go to WAIT if RspLatency>0, else RESP.
  - WAIT: a_ready=0; a 3-bit counter loads RspLatency-1 on entry and decrements; go to RESP when it reaches 0.
  - RESP: a_ready=0, d_valid=1. All D fields are held stable until d_ready. On d_valid&&d_ready go to IDLE.
- Latency: d_valid rises exactly 1+RspLatency cycles after the accept edge.
- Minimum request spacing: one IDLE cycle between the D handshake and the next accept. No accept in the same cycle as the D handshake.
- Response fields:
  - d_opcode=AccessAckData for Get, AccessAck for Put*.
  - d_source and d_size echo the captured values; d_param=0; d_sink=0.
  - d_data = register value for a successful Get, 32'hFFFF_FFFF for an erroring Get, 0 for Put*.
- Error conditions (any one sets d_error=1):
  - word index >= NumRegs;
  - a_address[1:0]!=0;
  - a_size!=2;
  - opcode not in {Get, PutFullData, PutPartialData};
  - PutFullData with a_mask!=4'hf.
- Erroring writes modify no register. Erroring requests still receive exactly one response.
- PutFullData: register <= a_data.
- PutPartialData: per byte b, register byte b <= a_data byte b when a_mask[b]=1. a_mask=0 is legal, writes nothing, no error.
- Get ignores a_mask and a_data.
- a_valid while not in IDLE is ignored, since a_ready=0. The host must hold the request, and it is accepted on return to IDLE.
- d_ready held high continuously is legal; the handshake completes in the first RESP cycle.
- Command integrity on tl_i is not checked.
- Reset asserted mid-transaction (WAIT or RESP) immediately clears state, registers and outputs to reset values. The pending response is dropped; no d_valid after reset release until a new accept.
- reg_o reflects the register update the cycle after the accept edge.

Test Plan:
- Reset, RspLatency=0: PutFullData addr 0x4 data 0xDEADBEEF, d_ready=1 → d_valid 1 cycle after accept; AccessAck, d_error=0. reg_o[63:32]=0xDEADBEEF. Get 0x4 → AccessAckData, d_data=0xDEADBEEF.
- PutPartialData addr 0x8, mask 4'b0101, data 0xAABBCCDD onto reg holding 0x11223344 → reg=0x11BB33DD. Get returns 0x11BB33DD. Repeat with mask 0 → value unchanged, d_error=0.
- Errors:
  - Get addr 0x20 (NumRegs=8) → d_error=1, d_data=0xFFFFFFFF.
  - PutFullData addr 0x6 → d_error=1, no register change.
  - PutFullData mask 4'h7 → d_error=1.
  - a_size=1 → d_error=1.
- RspLatency=3, d_ready held low 4 cycles after d_valid: d_valid rises 4 cycles after accept; a_ready=0 throughout; second request held on A is accepted only in the IDLE cycle after the D handshake. d_source=5 is echoed.
- Reset pulse while in RESP with d_ready=0 → d_valid=0 and reg_o=0 immediately, a_ready=1. No stale response after reset release.

Source files
------------

// File: rtl/tlul_reg_responder.sv
// TL-UL device-side register responder with configurable response latency.
// Includes the minimal TL-UL type package and response-integrity generator
// it depends on, so the block is self-contained.

package tlul_pkg;

    typedef enum logic [2:0] {
        PutFullData    = 3'h0,
        PutPartialData = 3'h1,
        Get            = 3'h4
    } tl_a_op_e;

    typedef enum logic [2:0] {
        AccessAck     = 3'h0,
        AccessAckData = 3'h1
    } tl_d_op_e;

    typedef struct packed {
        logic [6:0] cmd_intg;
        logic [6:0] data_intg;
    } tl_a_user_t;

    typedef struct packed {
        logic [6:0] rsp_intg;
        logic [6:0] data_intg;
    } tl_d_user_t;

    typedef struct packed {
        logic        a_valid;
        tl_a_op_e    a_opcode;
        logic [2:0]  a_param;
        logic [1:0]  a_size;
        logic [7:0]  a_source;
        logic [31:0] a_address;
        logic [3:0]  a_mask;
        logic [31:0] a_data;
        tl_a_user_t  a_user;
        logic        d_ready;
    } tl_h2d_t;

    typedef struct packed {
        logic        d_valid;
        tl_d_op_e    d_opcode;
        logic [2:0]  d_param;
        logic [1:0]  d_size;
        logic [7:0]  d_source;
        logic        d_sink;
        logic [31:0] d_data;
        tl_d_user_t  d_user;
        logic        d_error;
        logic        a_ready;
    } tl_d2h_t;

endpackage

// Fills d_user with integrity codes computed over the response metadata and data.
module tlul_rsp_intg_gen
    import tlul_pkg::*;
(
    input  tl_d2h_t tl_i,
    output tl_d2h_t tl_o
);

    // 7-lane parity fold: bit i of the input contributes to lane i mod 7.
    function automatic logic [6:0] fold7(input logic [55:0] v);
        logic [6:0] p;
        p = '0;
        for (int unsigned i = 0; i < 56; i++) begin
            p[3'(i % 7)] = p[3'(i % 7)] ^ v[i];
        end
        return p;
    endfunction

    // Pass the response through, replacing only the user/integrity field.
    always_comb begin
        tl_o                  = tl_i;
        tl_o.d_user.rsp_intg  = fold7({38'b0, tl_i.d_opcode, tl_i.d_param, tl_i.d_size,
                                       tl_i.d_source, tl_i.d_sink, tl_i.d_error});
        tl_o.d_user.data_intg = fold7({24'b0, tl_i.d_data});
    end

endmodule

module tlul_reg_responder
    import tlul_pkg::*;
#(
    parameter int unsigned NumRegs    = 8,
    parameter int unsigned RspLatency = 0
) (
    input  logic                   clk_i,
    input  logic                   rst_ni,
    input  tl_h2d_t                tl_i,
    output tl_d2h_t                tl_o,
    output logic [NumRegs*32-1:0]  reg_o
);

    typedef enum logic [1:0] {
        IDLE,
        WAIT,
        RESP
    } state_e;

    localparam logic [2:0] LatLoad = (RspLatency > 0) ? 3'(RspLatency - 1) : 3'd0;

    state_e      state_q, state_d;
    logic [2:0]  cnt_q;
    logic [31:0] regs_q [NumRegs];

    tl_d_op_e    op_q;
    logic [7:0]  src_q;
    logic [1:0]  size_q;
    logic [31:0] data_q;
    logic        err_q;

    logic        accept;
    logic        is_get;
    logic        is_put;
    logic        err;
    logic [29:0] word_idx;
    logic [31:0] rd_word;
    logic [31:0] wmask;
    tl_d2h_t     rsp_base;
    logic        unused_tl;

    assign unused_tl = ^{tl_i.a_param, tl_i.a_user};

    // Decode the A-channel request: legality, read mux and byte write mask.
    always_comb begin
        word_idx = tl_i.a_address[31:2];
        is_get   = (tl_i.a_opcode == Get);
        is_put   = (tl_i.a_opcode == PutFullData) || (tl_i.a_opcode == PutPartialData);
        err      = ({2'b0, word_idx} >= 32'(NumRegs))
                || (tl_i.a_address[1:0] != 2'b00)
                || (tl_i.a_size != 2'd2)
                || !(is_get || is_put)
                || ((tl_i.a_opcode == PutFullData) && (tl_i.a_mask != 4'hf));
        rd_word  = '0;
        for (int unsigned i = 0; i < NumRegs; i++) begin
            if (word_idx == 30'(i)) begin
                rd_word = regs_q[i];
            end
        end
        for (int unsigned b = 0; b < 4; b++) begin
            wmask[8*b +: 8] = {8{tl_i.a_mask[b]}};
        end
        accept = (state_q == IDLE) && tl_i.a_valid;
    end

    // Next-state logic: accept -> optional wait -> respond until d_ready.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE: begin
                if (accept) begin
                    state_d = (RspLatency > 0) ? WAIT : RESP;
                end
            end
            WAIT: begin
                if (cnt_q == 3'd0) begin
                    state_d = RESP;
                end
            end
            RESP: begin
                if (tl_i.d_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Latency counter: loaded at accept, counts down while waiting.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            cnt_q <= '0;
        end else if (accept) begin
            cnt_q <= LatLoad;
        end else if ((state_q == WAIT) && (cnt_q != 3'd0)) begin
            cnt_q <= cnt_q - 3'd1;
        end
    end

    // Capture response fields at the accept edge; they stay stable through RESP.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            op_q   <= AccessAck;
            src_q  <= '0;
            size_q <= '0;
            data_q <= '0;
            err_q  <= 1'b0;
        end else if (accept) begin
            op_q   <= is_get ? AccessAckData : AccessAck;
            src_q  <= tl_i.a_source;
            size_q <= tl_i.a_size;
            err_q  <= err;
            if (is_get) begin
                data_q <= err ? '1 : rd_word;
            end else begin
                data_q <= '0;
            end
        end
    end

    // Register bank: byte-masked write of a legal Put at the accept edge.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int unsigned i = 0; i < NumRegs; i++) begin
                regs_q[i] <= '0;
            end
        end else if (accept && !err && is_put) begin
            for (int unsigned i = 0; i < NumRegs; i++) begin
                if (word_idx == 30'(i)) begin
                    regs_q[i] <= (regs_q[i] & ~wmask) | (tl_i.a_data & wmask);
                end
            end
        end
    end

    // Flatten the register bank onto reg_o.
    always_comb begin
        reg_o = '0;
        for (int unsigned i = 0; i < NumRegs; i++) begin
            reg_o[32*i +: 32] = regs_q[i];
        end
    end

    // Assemble the D channel before integrity generation.
    always_comb begin
        rsp_base          = '0;
        rsp_base.d_valid  = (state_q == RESP);
        rsp_base.d_opcode = op_q;
        rsp_base.d_param  = 3'd0;
        rsp_base.d_size   = size_q;
        rsp_base.d_source = src_q;
        rsp_base.d_sink   = 1'b0;
        rsp_base.d_data   = data_q;
        rsp_base.d_error  = err_q;
        rsp_base.a_ready  = (state_q == IDLE);
    end

    tlul_rsp_intg_gen u_rsp_intg (
        .tl_i (rsp_base),
        .tl_o (tl_o)
    );

endmodule
